// File: rtl/em_param.sv
// Edge memory for a stochastic-decoder variable node, parametrised in depth.
// Latency: one cycle from IN/SEL to the registered OUT; LOAD and RESET clear OUT.
// Backpressure: none; EN is a per-decoding-cycle strobe and the block holds state while EN=0.
//
// Ports:
//   CLK       rising-edge clock
//   RESET     asynchronous active-high reset (mem=INIT, OUT=0, fill=0)
//   EN        decoding-cycle strobe; no state change when low (LOAD still acts)
//   LOAD      synchronous reload of the memory from LOAD_VAL, takes priority over EN
//   LOAD_VAL  reload pattern, bit k -> entry k
//   IN        incoming stochastic bit
//   HOLD      1 = node in hold state (read memory), 0 = regenerative (shift in, pass through)
//   SEL       random read address, wrapped into 0..DEPTH-1 by a single subtract
//   OUT       registered output bit
//   FULL      (EM_FILL_TRACK_EN only) 1 once DEPTH bits have been shifted in since reset/load
//
// Optional feature macro: EM_FILL_TRACK_EN
//   When defined, a saturating fill counter restricts hold reads to entries that were
//   actually shifted in since the last reset/load, and the FULL port is added.

module em_param #(
  parameter int              DEPTH = 8,
  parameter int              SELW  = 3,
  parameter logic [DEPTH-1:0] INIT = DEPTH'(8'hA5)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [DEPTH-1:0] LOAD_VAL,
  input  logic             IN,
  input  logic             HOLD,
  input  logic [SELW-1:0]  SEL,
  output logic             OUT
`ifdef EM_FILL_TRACK_EN
  ,
  output logic             FULL
`endif
);

  // Reject geometries where the single-subtract wrap cannot produce a legal index.
  if (DEPTH < 2 || SELW < 1 || (1 << SELW) < DEPTH || (1 << SELW) >= 2 * DEPTH) begin : g_bad_param
    $error("em_param: need DEPTH>=2 and DEPTH <= 2**SELW < 2*DEPTH");
  end

  localparam logic [SELW:0] DEPTH_X = (SELW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [DEPTH-1:0] mem_nxt;
  logic             out_nxt;
  logic [SELW:0]    sel_ext;
  logic [SELW:0]    sel_wrap;
  logic [SELW-1:0]  idx;
  logic [SELW-1:0]  rd_idx;

  // Wrap SEL into range. Out-of-range codes fold onto the low (newest) entries,
  // which slightly biases the draw for non-power-of-two depths; that bias is accepted.
  always_comb begin
    sel_ext  = {1'b0, SEL};
    sel_wrap = sel_ext - DEPTH_X;
    idx      = (sel_ext < DEPTH_X) ? SEL : sel_wrap[SELW-1:0];
  end

`ifdef EM_FILL_TRACK_EN
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [FW-1:0]   fill;
  logic [FW-1:0]   fill_nxt;
  logic [SELW-1:0] fill_mask;

  // fill_mask = P-1 where P is the largest power of two not above fill. Masking
  // by it keeps a hold read inside the entries shifted in since reset/load.
  // P <= fill <= DEPTH, so the masked index is always a real entry.
  always_comb begin
    fill_mask = '0;
    for (int i = 0; i < FW; i++) begin
      if (fill[i]) begin
        fill_mask = SELW'((1 << i) - 1);
      end
    end
  end

  // With nothing shifted in yet, fall back to the plain index so the
  // INIT/LOAD_VAL pattern is still readable.
  always_comb begin
    rd_idx = (fill != '0) ? (idx & fill_mask) : idx;
  end

  assign FULL = (fill == FILL_MAX);
`else
  always_comb begin
    rd_idx = idx;
  end
`endif

  // Next-state for memory and output, in priority order LOAD > !EN > shift > hold read.
  always_comb begin
    mem_nxt = mem;
    out_nxt = OUT;
    if (LOAD) begin
      mem_nxt = LOAD_VAL;
      out_nxt = 1'b0;
    end else if (EN) begin
      if (!HOLD) begin
        // Entry 0 is the newest bit; the oldest entry falls off the top.
        mem_nxt = {mem[DEPTH-2:0], IN};
        out_nxt = IN;
      end else begin
        // Read from the pre-edge contents; memory is untouched in hold.
        out_nxt = mem[rd_idx];
      end
    end
  end

`ifdef EM_FILL_TRACK_EN
  always_comb begin
    fill_nxt = fill;
    if (LOAD) begin
      fill_nxt = '0;
    end else if (EN && !HOLD && fill != FILL_MAX) begin
      fill_nxt = fill + FW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fill <= '0;
    end else begin
      fill <= fill_nxt;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem <= INIT;
      OUT <= 1'b0;
    end else begin
      mem <= mem_nxt;
      OUT <= out_nxt;
    end
  end

endmodule

// File: tb/tb_em_param.sv
// Scoreboarded directed bench for em_param: one default instance (DEPTH=8)
// and one non-power-of-two instance (DEPTH=6). Stimulus pushes the expected
// OUT for each driven edge; a monitor pops and compares one cycle later.

module tb_em_param;

  logic       clk;
  logic       rst8, en8, load8, in8, hold8, out8;
  logic [7:0] lv8;
  logic [2:0] sel8;
  logic       rst6, en6, load6, in6, hold6, out6;
  logic [5:0] lv6;
  logic [2:0] sel6;
`ifdef EM_FILL_TRACK_EN
  logic       full8, full6;
`endif

  em_param #(.DEPTH(8), .SELW(3), .INIT(8'hA5)) u_dut8 (
    .CLK(clk), .RESET(rst8), .EN(en8), .LOAD(load8), .LOAD_VAL(lv8),
    .IN(in8), .HOLD(hold8), .SEL(sel8), .OUT(out8)
`ifdef EM_FILL_TRACK_EN
    , .FULL(full8)
`endif
  );

  em_param #(.DEPTH(6), .SELW(3), .INIT(6'b110011)) u_dut6 (
    .CLK(clk), .RESET(rst6), .EN(en6), .LOAD(load6), .LOAD_VAL(lv6),
    .IN(in6), .HOLD(hold6), .SEL(sel6), .OUT(out6)
`ifdef EM_FILL_TRACK_EN
    , .FULL(full6)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int    dut;
    bit    chk;
    logic  exp;
    string name;
  } item_t;

  item_t sbq[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic check(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b want %0b", nm, got, exp);
  endtask

  // Monitor: one scoreboard entry per driven edge, compared just after the edge.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (sbq.size() != 0) begin
      it = sbq.pop_front();
      if (it.chk) check(it.name, (it.dut == 8) ? out8 : out6, it.exp);
    end
  end

  task automatic push(input int dut, input bit chk, input logic exp, input string nm);
    item_t it;
    it.dut = dut; it.chk = chk; it.exp = exp; it.name = nm;
    sbq.push_back(it);
  endtask

  // Drive one edge of the 8-deep instance (called just after a falling edge).
  task automatic step8(input logic en, input logic ld, input logic [7:0] lv, input logic hold,
                       input logic in, input logic [2:0] sel, input logic exp, input string nm);
    en8 = en; load8 = ld; lv8 = lv; hold8 = hold; in8 = in; sel8 = sel;
    push(8, 1'b1, exp, nm);
    @(negedge clk);
  endtask

  task automatic step6(input logic en, input logic ld, input logic [5:0] lv, input logic hold,
                       input logic in, input logic [2:0] sel, input logic exp, input string nm);
    en6 = en; load6 = ld; lv6 = lv; hold6 = hold; in6 = in; sel6 = sel;
    push(6, 1'b1, exp, nm);
    @(negedge clk);
  endtask

  task automatic idle8();
    en8 = 1'b0; load8 = 1'b0;
  endtask

  task automatic idle6();
    en6 = 1'b0; load6 = 1'b0;
  endtask

  task automatic rst_pulse8(input string nm);
    idle8();
    rst8 = 1'b1;
    #1 check(nm, out8, 1'b0);
    @(negedge clk);
    rst8 = 1'b0;
  endtask

  task automatic rst_pulse6(input string nm);
    idle6();
    rst6 = 1'b1;
    #1 check(nm, out6, 1'b0);
    @(negedge clk);
    rst6 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; lv8 = '0; in8 = 1'b0; hold8 = 1'b0; sel8 = '0;
    rst6 = 1'b1; en6 = 1'b0; load6 = 1'b0; lv6 = '0; in6 = 1'b0; hold6 = 1'b0; sel6 = '0;

    // Test 1: reset state, then hold reads of INIT 0xA5.
    #1 check("t1_reset_out8", out8, 1'b0);
    check("t1_reset_out6", out6, 1'b0);
    @(negedge clk);
    en8 = 1'b1; hold8 = 1'b1; sel8 = 3'd0;
    @(negedge clk);
    check("t1_reset_held_out8", out8, 1'b0);
    idle8();
    rst8 = 1'b0; rst6 = 1'b0;
    step8(1, 0, 8'h00, 1, 0, 3'd0, 1'b1, "t1_sel0");
    step8(1, 0, 8'h00, 1, 0, 3'd1, 1'b0, "t1_sel1");
    step8(1, 0, 8'h00, 1, 0, 3'd2, 1'b1, "t1_sel2");
    step8(1, 0, 8'h00, 1, 0, 3'd7, 1'b1, "t1_sel7");

    // Test 2: shift 1,1,0 then read back (mem becomes 0x2E).
    rst_pulse8("t2_reset_out");
    step8(1, 0, 8'h00, 0, 1, 3'd0, 1'b1, "t2_shift1a");
    step8(1, 0, 8'h00, 0, 1, 3'd0, 1'b1, "t2_shift1b");
    step8(1, 0, 8'h00, 0, 0, 3'd0, 1'b0, "t2_shift0");
    step8(1, 0, 8'h00, 1, 0, 3'd0, 1'b0, "t2_hold_sel0");
    step8(1, 0, 8'h00, 1, 0, 3'd1, 1'b1, "t2_hold_sel1");
    step8(1, 0, 8'h00, 1, 0, 3'd3, 1'b1, "t2_hold_sel3");

    // Test 4: five stalled cycles with IN toggling; OUT and memory must not move.
    for (int i = 0; i < 5; i++) begin
      step8(0, 0, 8'h00, 0, logic'(i % 2 == 0), 3'd0, 1'b1, "t4_stall_out");
    end
    step8(1, 0, 8'h00, 1, 0, 3'd0, 1'b0, "t4_after_stall_sel0");
    step8(1, 0, 8'h00, 1, 0, 3'd3, 1'b1, "t4_after_stall_sel3");

    // Test 5: LOAD wins over a concurrent shift, then async reset between edges.
    step8(1, 1, 8'h0F, 0, 1, 3'd0, 1'b0, "t5_load_out");
    step8(1, 0, 8'h00, 1, 0, 3'd4, 1'b0, "t5_load_sel4");
    step8(1, 0, 8'h00, 1, 0, 3'd3, 1'b1, "t5_load_sel3");
    idle8();
    #2 rst8 = 1'b1;
    #1 check("t5_midcycle_reset_out", out8, 1'b0);
    #1 rst8 = 1'b0;
    @(negedge clk);
    step8(1, 0, 8'h00, 1, 0, 3'd0, 1'b1, "t5_post_reset_sel0");
    idle8();

    // Test 3: non-power-of-two depth, LOAD with EN low, wrapped addresses.
    rst_pulse6("t3_reset_out6");
    step6(1, 0, 6'b0, 1, 0, 3'd0, 1'b1, "t3_init_sel0");
    step6(0, 1, 6'b000010, 0, 0, 3'd0, 1'b0, "t3_load_en0_out");
    step6(1, 0, 6'b0, 1, 0, 3'd7, 1'b1, "t3_sel7_wrap");
    step6(1, 0, 6'b0, 1, 0, 3'd6, 1'b0, "t3_sel6_wrap");
    step6(1, 0, 6'b0, 1, 0, 3'd5, 1'b0, "t3_sel5");
    step6(1, 0, 6'b0, 1, 0, 3'd1, 1'b1, "t3_sel1");
    step6(1, 0, 6'b0, 0, 1, 3'd0, 1'b1, "t3_shift1");
    step6(1, 0, 6'b0, 1, 0, 3'd6, 1'b1, "t3_shift_sel6");
    step6(1, 0, 6'b0, 1, 0, 3'd7, 1'b0, "t3_shift_sel7");
    step6(1, 0, 6'b0, 1, 0, 3'd2, 1'b1, "t3_shift_sel2");
    idle6();

`ifdef EM_FILL_TRACK_EN
    // Test 6: fill tracking and FULL on the 8-deep instance.
    rst_pulse8("t6_reset_out");
    check("t6_reset_full", full8, 1'b0);
    step8(1, 0, 8'h00, 1, 0, 3'd7, 1'b1, "t6_fill0_sel7_init");
    for (int i = 0; i < 3; i++) begin
      step8(1, 0, 8'h00, 0, 0, 3'd0, 1'b0, "t6_shift0");
      check("t6_full_early", full8, 1'b0);
    end
    step8(1, 0, 8'h00, 1, 0, 3'd7, 1'b0, "t6_fill3_sel7");
    step8(1, 0, 8'h00, 1, 0, 3'd5, 1'b0, "t6_fill3_sel5");
    for (int i = 4; i <= 8; i++) begin
      step8(1, 0, 8'h00, 0, 1, 3'd0, 1'b1, "t6_shift1");
      check("t6_full_count", full8, logic'(i == 8));
    end
    step8(1, 0, 8'h00, 0, 0, 3'd0, 1'b0, "t6_shift_past_full");
    check("t6_full_sticky", full8, 1'b1);
    step8(1, 0, 8'h00, 1, 0, 3'd5, 1'b1, "t6_full_sel5");
    idle8();
`endif

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
